lns_to_linear: RTL

Sequential decoder from the datapath's LNS format back to linear fixed-point: the inverse of the piecewise-linear log-domain arithmetic, evaluating 2^x for an 11-bit Q3.8 log value. It sits at the output boundary of the LNS fused multiply-add and feeds linear consumers through valid/ready handshakes on both sides. The mantissa is computed with Mitchell's approximation plus a quadratic correction. The correction product comes from an iterative shift-add multiplier, so the block is multi-cycle.

---
 rtl/lns_to_linear.sv | 117 +++++++++++
 1 files changed

// File: rtl/lns_to_linear.sv
// LNS (Q3.8 log2) to linear Q4.12 decoder: Mitchell mantissa with a quadratic
// correction whose f*g product is built by a 9-cycle LSB-first shift-add loop.
module lns_to_linear (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic        in_zero,
  input  logic [10:0] in_log,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic        out_zero,
  output logic [15:0] out_mag,
  output logic [1:0]  dbg_state
);

  // Handshakes: a word moves on a rising edge where valid and ready are both
  // high. in_ready is high only in IDLE; out_valid is high only in DONE, and
  // out_* hold still until out_ready is seen there.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_sign;
  logic        r_zero;
  logic [2:0]  r_shift;
  logic [7:0]  r_f;
  logic [8:0]  r_g;
  logic [16:0] r_acc;
  logic [3:0]  r_cnt;
  logic        r_out_sign;
  logic        r_out_zero;
  logic [15:0] r_out_mag;

  logic [16:0] w_addend;
  logic [8:0]  w_corr;
  logic [8:0]  w_m;
  logic [15:0] w_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_MUL;
      S_MUL:   if (r_cnt == 4'd8) w_next = S_NORM;
      S_NORM:  w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_addend = {9'd0, r_f} << r_cnt;
  assign w_corr   = {2'd0, r_acc[16:10]} + {4'd0, r_acc[16:12]};
  assign w_m      = 9'd256 + {1'b0, r_f} - w_corr;
  assign w_mag    = {7'd0, w_m} << r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_shift    <= 3'd0;
      r_f        <= 8'd0;
      r_g        <= 9'd0;
      r_acc      <= 17'd0;
      r_cnt      <= 4'd0;
      r_out_sign <= 1'b0;
      r_out_zero <= 1'b0;
      r_out_mag  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign  <= in_sign;
            r_zero  <= in_zero;
            // k+4 for k = floor(log/256) in -4..3 is the exponent field with its MSB flipped
            r_shift <= {~in_log[10], in_log[9:8]};
            r_f     <= in_log[7:0];
            r_g     <= 9'd256 - {1'b0, in_log[7:0]};
            r_acc   <= 17'd0;
            r_cnt   <= 4'd0;
          end
        end
        S_MUL: begin
          if (r_g[r_cnt]) r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + 4'd1;
        end
        S_NORM: begin
          r_out_sign <= r_sign;
          r_out_zero <= r_zero;
          r_out_mag  <= r_zero ? 16'd0 : w_mag;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_sign  = r_out_sign;
  assign out_zero  = r_out_zero;
  assign out_mag   = r_out_mag;
  assign dbg_state = r_state;

endmodule
